// File: rtl/sprite_rom_arbiter.sv
// Round-robin arbiter sharing one registered-read sprite ROM among NUM_REQ requesters.
// Grants at most one read per cycle; the ROM word returns to the winner one cycle later.
module sprite_rom_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ADDR_W  = 19,
    parameter int DATA_W  = 5,
    parameter int DEPTH   = 2400
) (
    input  logic                      Clk,
    input  logic                      Reset_n,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    output logic [NUM_REQ-1:0]        gnt,
    output logic [ADDR_W-1:0]         rom_addr,
    input  logic [DATA_W-1:0]         rom_data,
    output logic [NUM_REQ-1:0]        rsp_valid,
    output logic [DATA_W-1:0]         rsp_data,
    output logic                      oor_err
);

    localparam int PTR_W = $clog2(NUM_REQ);
    // One extra bit so DEPTH == 2**ADDR_W still compares correctly.
    localparam logic [ADDR_W:0] DEPTH_X = (ADDR_W+1)'(DEPTH);

    logic [PTR_W-1:0]  ptr;
    logic [PTR_W-1:0]  win;
    logic [PTR_W-1:0]  idx;
    logic [PTR_W-1:0]  ptr_next;
    logic              found;
    logic              grant;
    logic              oor;
    logic [ADDR_W-1:0] addr_arr [NUM_REQ];
    logic [ADDR_W-1:0] win_addr;

    logic              p_vld;
    logic [PTR_W-1:0]  p_id;
    logic              p_oor;

    always_comb begin
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            addr_arr[i] = req_addr[i*ADDR_W +: ADDR_W];
        end
    end

    // Search from ptr upward with wrap; first set request wins.
    always_comb begin
        found = 1'b0;
        win   = '0;
        idx   = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            idx = PTR_W'((32'(ptr) + k) % NUM_REQ);
            if (!found && req[idx]) begin
                found = 1'b1;
                win   = idx;
            end
        end
    end

    always_comb begin
        win_addr = addr_arr[win];
        oor      = ({1'b0, win_addr} >= DEPTH_X);
        grant    = found && Reset_n;
        ptr_next = (win == PTR_W'(NUM_REQ-1)) ? '0 : win + 1'b1;
    end

    always_comb begin
        gnt      = grant ? (NUM_REQ'(1) << win) : '0;
        rom_addr = (grant && !oor) ? win_addr : '0;
    end

    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            ptr   <= '0;
            p_vld <= 1'b0;
            p_id  <= '0;
            p_oor <= 1'b0;
        end else begin
            p_vld <= found;
            if (found) begin
                ptr   <= ptr_next;
                p_id  <= win;
                p_oor <= oor;
            end
        end
    end

    always_comb begin
        rsp_valid = (Reset_n && p_vld) ? (NUM_REQ'(1) << p_id) : '0;
        rsp_data  = (Reset_n && p_vld && !p_oor) ? rom_data : '0;
        oor_err   = Reset_n && p_vld && p_oor;
    end

endmodule

// File: tb/tb_sprite_rom_arbiter.sv
// Bench for sprite_rom_arbiter: directed vector table plus randomized traffic,
// with a reference arbiter and a response scoreboard.
module tb_sprite_rom_arbiter;

    localparam int NUM_REQ = 4;
    localparam int ADDR_W  = 19;
    localparam int DATA_W  = 5;
    localparam int DEPTH   = 2400;

    logic                      Clk = 1'b0;
    logic                      Reset_n = 1'b0;
    logic [NUM_REQ-1:0]        req = '0;
    logic [NUM_REQ*ADDR_W-1:0] req_addr = '0;
    logic [NUM_REQ-1:0]        gnt;
    logic [ADDR_W-1:0]         rom_addr;
    logic [DATA_W-1:0]         rom_data = '0;
    logic [NUM_REQ-1:0]        rsp_valid;
    logic [DATA_W-1:0]         rsp_data;
    logic                      oor_err;

    sprite_rom_arbiter #(
        .NUM_REQ (NUM_REQ),
        .ADDR_W  (ADDR_W),
        .DATA_W  (DATA_W),
        .DEPTH   (DEPTH)
    ) dut (
        .Clk       (Clk),
        .Reset_n   (Reset_n),
        .req       (req),
        .req_addr  (req_addr),
        .gnt       (gnt),
        .rom_addr  (rom_addr),
        .rom_data  (rom_data),
        .rsp_valid (rsp_valid),
        .rsp_data  (rsp_data),
        .oor_err   (oor_err)
    );

    always #5 Clk = ~Clk;

    function automatic logic [DATA_W-1:0] mem_word(input logic [ADDR_W-1:0] a);
        return a[4:0] ^ a[9:5] ^ a[14:10] ^ 5'd7;
    endfunction

    // Frame ROM: registered read
    always @(posedge Clk) rom_data <= mem_word(rom_addr);

    typedef struct {
        logic [NUM_REQ-1:0] id_oh;
        logic [DATA_W-1:0]  data;
        logic               oor;
    } rsp_t;

    typedef struct {
        bit                 rst;
        logic [NUM_REQ-1:0] req;
        logic [ADDR_W-1:0]  a0, a1, a2, a3;
        logic [NUM_REQ-1:0] gnt;
        logic [ADDR_W-1:0]  ra;
    } vec_t;

    rsp_t sbq[$];
    int   passed = 0;
    int   total  = 0;
    int   mptr   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    function automatic int find_win(input logic [NUM_REQ-1:0] r, input int p);
        for (int k = 0; k < NUM_REQ; k++) begin
            if (r[(p + k) % NUM_REQ]) return (p + k) % NUM_REQ;
        end
        return -1;
    endfunction

    function automatic logic [ADDR_W-1:0] rand_addr();
        case ($urandom_range(0, 9))
            0:       return ADDR_W'($urandom_range(DEPTH-5, DEPTH+5));
            1:       return ADDR_W'($urandom);
            default: return ADDR_W'($urandom_range(0, DEPTH-1));
        endcase
    endfunction

    // Entered just after a rising edge; returns just after the next one.
    task automatic drive_cycle(input logic [NUM_REQ-1:0] r,
                               input logic [NUM_REQ*ADDR_W-1:0] a,
                               output logic [NUM_REQ-1:0] g,
                               output logic [ADDR_W-1:0] ra);
        int                 w;
        rsp_t               exp_rsp;
        rsp_t               got;
        logic [ADDR_W-1:0]  wa;
        logic [NUM_REQ-1:0] exp_gnt;
        logic [ADDR_W-1:0]  exp_ra;
        req = r;
        req_addr = a;
        @(negedge Clk);
        g  = gnt;
        ra = rom_addr;
        w = find_win(r, mptr);
        exp_rsp = '{id_oh: '0, data: '0, oor: 1'b0};
        exp_gnt = '0;
        exp_ra  = '0;
        if (w >= 0) begin
            wa = a[w*ADDR_W +: ADDR_W];
            exp_gnt = NUM_REQ'(1) << w;
            exp_rsp.id_oh = exp_gnt;
            exp_rsp.oor = (32'(wa) >= DEPTH);
            exp_rsp.data = exp_rsp.oor ? '0 : mem_word(wa);
            exp_ra = exp_rsp.oor ? '0 : wa;
            mptr = (w + 1) % NUM_REQ;
        end
        check("model_gnt", 32'(gnt), 32'(exp_gnt));
        check("model_rom_addr", 32'(rom_addr), 32'(exp_ra));
        if (sbq.size() == 0) begin
            check("scoreboard_empty", 32'(sbq.size()), 32'd1);
        end else begin
            got = sbq.pop_front();
            check("rsp_valid", 32'(rsp_valid), 32'(got.id_oh));
            check("rsp_data", 32'(rsp_data), 32'(got.data));
            check("oor_err", 32'(oor_err), 32'(got.oor));
        end
        sbq.push_back(exp_rsp);
        @(posedge Clk);
        #1;
    endtask

    // Outputs must stay quiet through reset, even with a read in flight.
    task automatic do_reset();
        Reset_n = 1'b0;
        req = '0;
        req_addr = '0;
        for (int i = 0; i < 2; i++) begin
            @(negedge Clk);
            check("rst_gnt", 32'(gnt), 32'd0);
            check("rst_rom_addr", 32'(rom_addr), 32'd0);
            check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
            check("rst_rsp_data", 32'(rsp_data), 32'd0);
            check("rst_oor_err", 32'(oor_err), 32'd0);
            @(posedge Clk);
            #1;
        end
        Reset_n = 1'b1;
        sbq.delete();
        sbq.push_back('{id_oh: '0, data: '0, oor: 1'b0});
        mptr = 0;
    endtask

    initial begin
        vec_t               vecs[$];
        logic [NUM_REQ-1:0] g;
        logic [ADDR_W-1:0]  ra;
        logic [NUM_REQ-1:0] rr;
        logic [ADDR_W-1:0]  ar [NUM_REQ];
        int                 wait_c [NUM_REQ];

        // single request after reset
        vecs.push_back('{rst:1, req:4'b0001, a0:10,  a1:0,   a2:0,   a3:0,    gnt:4'b0001, ra:10});
        // all requesting: strict rotation starting at 0
        for (int n = 0; n < 8; n++) begin
            vecs.push_back('{rst:(n == 0), req:4'b1111, a0:100, a1:201, a2:302, a3:2399,
                             gnt:4'(1 << (n % 4)),
                             ra:((n % 4) == 0) ? 19'd100 : ((n % 4) == 1) ? 19'd201 :
                                ((n % 4) == 2) ? 19'd302 : 19'd2399});
        end
        // pointer at 1: 0101 wins 2, then wraps to 0
        vecs.push_back('{rst:0, req:4'b0001, a0:5,   a1:0,   a2:0,   a3:0,    gnt:4'b0001, ra:5});
        vecs.push_back('{rst:0, req:4'b0101, a0:7,   a1:0,   a2:9,   a3:0,    gnt:4'b0100, ra:9});
        vecs.push_back('{rst:0, req:4'b0101, a0:7,   a1:0,   a2:11,  a3:0,    gnt:4'b0001, ra:7});
        // range boundary
        vecs.push_back('{rst:0, req:4'b0010, a0:0,   a1:2400, a2:0,  a3:0,    gnt:4'b0010, ra:0});
        vecs.push_back('{rst:0, req:4'b0010, a0:0,   a1:2399, a2:0,  a3:0,    gnt:4'b0010, ra:2399});
        vecs.push_back('{rst:0, req:4'b0010, a0:0,   a1:19'h7FFFF, a2:0, a3:0, gnt:4'b0010, ra:0});
        vecs.push_back('{rst:0, req:4'b0000, a0:0,   a1:0,   a2:0,   a3:0,    gnt:4'b0000, ra:0});
        // grant to 2, then reset with the read in flight
        vecs.push_back('{rst:0, req:4'b0100, a0:0,   a1:0,   a2:33,  a3:0,    gnt:4'b0100, ra:33});
        vecs.push_back('{rst:1, req:4'b1010, a0:0,   a1:44,  a2:0,   a3:55,   gnt:4'b0010, ra:44});
        vecs.push_back('{rst:1, req:4'b1000, a0:0,   a1:0,   a2:0,   a3:55,   gnt:4'b1000, ra:55});
        vecs.push_back('{rst:0, req:4'b0000, a0:0,   a1:0,   a2:0,   a3:0,    gnt:4'b0000, ra:0});

        foreach (vecs[i]) begin
            if (vecs[i].rst) do_reset();
            drive_cycle(vecs[i].req, {vecs[i].a3, vecs[i].a2, vecs[i].a1, vecs[i].a0}, g, ra);
            check($sformatf("vec%0d_gnt", i), 32'(g), 32'(vecs[i].gnt));
            check($sformatf("vec%0d_rom_addr", i), 32'(ra), 32'(vecs[i].ra));
        end

        // Random traffic honouring the hold-until-grant handshake
        rr = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            ar[i] = '0;
            wait_c[i] = 0;
        end
        for (int c = 0; c < 10000; c++) begin
            drive_cycle(rr, {ar[3], ar[2], ar[1], ar[0]}, g, ra);
            for (int i = 0; i < NUM_REQ; i++) begin
                if (g[i]) begin
                    check("max_wait_ok", 32'(wait_c[i] <= NUM_REQ-1), 32'd1);
                    wait_c[i] = 0;
                    if ($urandom_range(0, 2) == 0) rr[i] = 1'b0;
                    else ar[i] = rand_addr();
                end else if (rr[i]) begin
                    wait_c[i]++;
                end else if ($urandom_range(0, 1) == 1) begin
                    rr[i] = 1'b1;
                    ar[i] = rand_addr();
                    wait_c[i] = 0;
                end
            end
        end
        drive_cycle('0, '0, g, ra);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
